// File: rtl/seg_scan_drv.sv
// seg_scan_drv: 8-digit multiplexed hex scan driver with load-latched shadow registers.
// Define SEG_SCAN_CURSOR_BLINK_EN to compile in cursor-digit blinking.
module seg_scan_drv #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  input  logic [7:0]  digit_en,
  input  logic [2:0]  cursor,
  output logic [2:0]  an,
  output logic [3:0]  hex,
  output logic        blank,
  output logic        frame
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] psc_q, psc_d;
  logic [31:0]   dig_q, dig_d;
  logic [7:0]    en_q, en_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    hex_q, hex_d;
  logic          blank_q, blank_d, frame_q, frame_d;
  logic          tick, found;
  logic [2:0]    nxt;
  logic [7:0]    vis;
`ifdef SEG_SCAN_CURSOR_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [2:0]    cur_q, cur_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bon_q, bon_d, bwrap;
  assign vis = en_q & ~(bon_q ? 8'h00 : 8'h01 << cur_q);
  always_comb begin
    cur_d  = load ? cursor : cur_q;
    bwrap  = bcnt_q == BW'(BLINK_DIV - 1);
    bcnt_d = frame_d ? (bwrap ? '0 : bcnt_q + BW'(1)) : bcnt_q;
    bon_d  = bon_q ^ (frame_d & bwrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= '0;
      bcnt_q <= '0;
      bon_q  <= 1'b1;
    end else begin
      cur_q  <= cur_d;
      bcnt_q <= bcnt_d;
      bon_q  <= bon_d;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor;
  assign vis = en_q;
`endif
  // nearest visible digit after an_q; k=8 lands on an_q itself as the last resort
  always_comb begin
    found = 1'b0;
    nxt   = an_q;
    for (int k = 8; k >= 1; k--) begin
      if (vis[an_q + 3'(k)]) begin
        found = 1'b1;
        nxt   = an_q + 3'(k);
      end
    end
  end
  always_comb begin
    tick    = psc_q == PW'(SCAN_DIV - 1);
    psc_d   = tick ? '0 : psc_q + PW'(1);
    dig_d   = load ? d : dig_q;
    en_d    = load ? digit_en : en_q;
    an_d    = tick && found ? nxt : an_q;
    hex_d   = tick && found ? dig_q[{nxt, 2'b00} +: 4] : hex_q;
    blank_d = tick ? !found : blank_q;
    frame_d = tick && found && nxt <= an_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      dig_q   <= '0;
      en_q    <= 8'hFF;
      an_q    <= '0;
      hex_q   <= '0;
      blank_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
    end
  end
  assign an    = an_q;
  assign hex   = hex_q;
  assign blank = blank_q;
  assign frame = frame_q;
endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: directed vector table, blink sequence and randomized run against a digit-level reference model.
module tb_seg_scan_drv;
  localparam int SD = 4;
  localparam int BD = 2;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] d;
  logic [7:0]  digit_en;
  logic [2:0]  cursor;
  logic [2:0]  an;
  logic [3:0]  hex;
  logic        blank, frame;
  int checks = 0;
  int errors = 0;
  int m_psc, m_an, m_hex, m_blank, m_frame, m_bcnt, m_bon, m_cur;
  int m_dig[8];
  bit [7:0] m_en;

  seg_scan_drv #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .load(load), .d(d), .digit_en(digit_en), .cursor(cursor),
    .an(an), .hex(hex), .blank(blank), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic bit m_vis(int j);
`ifdef SEG_SCAN_CURSOR_BLINK_EN
    return m_en[j] && !(m_bon == 0 && j == m_cur);
`else
    return m_en[j];
`endif
  endfunction

  task automatic model_step();
    int f;
    if (rst) begin
      m_psc = 0; m_an = 0; m_hex = 0; m_blank = 0; m_frame = 0;
      m_bcnt = 0; m_bon = 1; m_cur = 0; m_en = 8'hFF;
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
    end else begin
      m_frame = 0;
      if (m_psc == SD - 1) begin
        f = -1;
        for (int k = 1; k <= 8; k++)
          if (f < 0 && m_vis((m_an + k) % 8)) f = (m_an + k) % 8;
        if (f < 0) m_blank = 1;
        else begin
          m_frame = (f <= m_an) ? 1 : 0;
          m_an = f; m_hex = m_dig[f]; m_blank = 0;
        end
`ifdef SEG_SCAN_CURSOR_BLINK_EN
        if (m_frame == 1) begin
          m_bcnt++;
          if (m_bcnt == BD) begin m_bcnt = 0; m_bon = 1 - m_bon; end
        end
`endif
        m_psc = 0;
      end else m_psc++;
      if (load) begin
        for (int i = 0; i < 8; i++) m_dig[i] = int'((d >> (4 * i)) & 32'hF);
        m_en = digit_en; m_cur = int'(cursor);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic ld; logic [31:0] dd; logic [7:0] en; logic [2:0] cur;
    int n; int e_an; int e_hex; int e_blank; int e_frame;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int n3, n24, prev;
    tbl[0]  = '{0, 32'h0, 8'h00, 3'd0, 4,  1, 0, 0, 0};
    tbl[1]  = '{0, 32'h0, 8'h00, 3'd0, 27, 7, 0, 0, 0};
    tbl[2]  = '{0, 32'h0, 8'h00, 3'd0, 1,  0, 0, 0, 1};
    tbl[3]  = '{1, 32'h76543210, 8'hFF, 3'd7, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 32'h0, 8'h00, 3'd0, 3,  1, 1, 0, 0};
    tbl[5]  = '{0, 32'h0, 8'h00, 3'd0, 8,  3, 3, 0, 0};
    tbl[6]  = '{1, 32'h76543210, 8'b00100100, 3'd7, 4, 5, 5, 0, 0};
    tbl[7]  = '{0, 32'h0, 8'h00, 3'd0, 4,  2, 2, 0, 1};
    tbl[8]  = '{0, 32'h0, 8'h00, 3'd0, 4,  5, 5, 0, 0};
    tbl[9]  = '{1, 32'h76543210, 8'h00, 3'd7, 4, 5, 5, 1, 0};
    tbl[10] = '{0, 32'h0, 8'h00, 3'd0, 8,  5, 5, 1, 0};
    tbl[11] = '{1, 32'h76543210, 8'h01, 3'd7, 4, 0, 0, 0, 1};
    tbl[12] = '{0, 32'h0, 8'h00, 3'd0, 4,  0, 0, 0, 1};
    tbl[13] = '{0, 32'h0, 8'h00, 3'd0, 1,  0, 0, 0, 0};
    tbl[14] = '{0, 32'h0, 8'h00, 3'd0, 2,  0, 0, 0, 0};
    tbl[15] = '{1, 32'h76543210, 8'h02, 3'd7, 1, 0, 0, 0, 1};
    tbl[16] = '{0, 32'h0, 8'h00, 3'd0, 4,  1, 1, 0, 0};
    tbl[17] = '{0, 32'h0, 8'h00, 3'd0, 4,  1, 1, 0, 1};
    rst = 1; load = 0; d = 0; digit_en = 0; cursor = 0;
    step();
    check("reset_an", int'(an), 0);
    check("reset_hex", int'(hex), 0);
    check("reset_blank", int'(blank), 0);
    check("reset_frame", int'(frame), 0);
    rst = 0;
    foreach (tbl[v]) begin
      load = tbl[v].ld; d = tbl[v].dd; digit_en = tbl[v].en; cursor = tbl[v].cur;
      step();
      load = 0;
      repeat (tbl[v].n - 1) step();
      check($sformatf("vec%0d_an", v), int'(an), tbl[v].e_an);
      check($sformatf("vec%0d_hex", v), int'(hex), tbl[v].e_hex);
      check($sformatf("vec%0d_blank", v), int'(blank), tbl[v].e_blank);
      check($sformatf("vec%0d_frame", v), int'(frame), tbl[v].e_frame);
    end
    // reset on a slot-boundary edge with load high: boundary and load both discarded
    repeat (3) step();
    rst = 1; load = 1; d = 32'hFFFF_FFFF; digit_en = 8'h00; cursor = 3'd5;
    step();
    rst = 0; load = 0;
    check("rst_load_an", int'(an), 0);
    check("rst_load_hex", int'(hex), 0);
    check("rst_load_blank", int'(blank), 0);
    check("rst_load_frame", int'(frame), 0);
    repeat (4) step();
    check("post_rst_an", int'(an), 1);
    check("post_rst_hex", int'(hex), 0);
    check("post_rst_blank", int'(blank), 0);
    rst = 1; step(); rst = 0;
    n3 = 0; n24 = 0; prev = 0;
    d = 32'h76543210; digit_en = 8'hFF; cursor = 3'd3;
    for (int s = 1; s <= 120; s++) begin
      load = (s == 1);
      step();
      if (s % SD == 0) begin
        if (an == 3'd3) n3++;
        if (prev == 2 && an == 3'd4) n24++;
        prev = int'(an);
      end
    end
    load = 0;
`ifdef SEG_SCAN_CURSOR_BLINK_EN
    check("blink_shown_count", n3, 2);
    check("blink_skip_count", n24, 2);
`else
    check("noblink_shown_count", n3, 4);
    check("noblink_skip_count", n24, 0);
`endif
    for (int s = 0; s < 3000; s++) begin
      rst = ($urandom % 300) == 0;
      load = ($urandom % 6) == 0;
      d = $urandom;
      case ($urandom % 4)
        0: digit_en = 8'($urandom);
        1: digit_en = 8'h01 << ($urandom % 8);
        2: digit_en = 8'h00;
        default: digit_en = 8'hFF;
      endcase
      cursor = 3'($urandom);
      step();
      check("rnd_an", int'(an), m_an);
      check("rnd_hex", int'(hex), m_hex);
      check("rnd_blank", int'(blank), m_blank);
      check("rnd_frame", int'(frame), m_frame);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 250, frames per cursor blink half-period (min 1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  one-cycle pulse; latch d, digit_en, cursor into shadow registers.
REQ-006 SHALL have port d  input  32  eight hex digits; digit i = d[4i+3:4i].
REQ-007 SHALL have port digit_en  input  8  per-digit enable; 0 = digit skipped by scan.
REQ-008 SHALL have port cursor  input  3  index of blinking digit.
REQ-009 SHALL have port an  output  3  index of digit currently driven.
REQ-010 SHALL have port hex  output  4  hex value of digit currently driven.
REQ-011 SHALL have port blank  output  1  1 = no digit driven; an/hex hold their last values.
REQ-012 SHALL have port frame  output  1  one-cycle pulse when the scan index wraps from a higher to an equal-or-lower index.

Function
REQ-013 SHALL display only shadow-register contents; d, digit_en, cursor changes without load SHALL have no effect.
REQ-014 SHALL update shadow registers on the cycle after load is sampled high; the new value becomes visible at the next slot boundary.
REQ-015 SHALL count a prescaler 0..SCAN_DIV-1; a slot boundary occurs when it wraps to 0.
REQ-016 At each slot boundary SHALL advance an to the next visible index above the current one, wrapping 7->0, searching at most 8 positions.
REQ-017 A digit SHALL be visible when its shadow enable is 1 and it is not blink-suppressed.
REQ-018 If the current index is the only visible digit, an SHALL remain unchanged and frame SHALL pulse every slot boundary.
REQ-019 If no digit is visible, blank SHALL be 1 from the next slot boundary, and an/hex SHALL hold; blank SHALL clear at the first boundary with a visible digit.
REQ-020 hex SHALL equal shadow digit[an], registered; an and hex SHALL change in the same cycle.
REQ-021 frame SHALL be asserted exactly one cycle, coincident with the an update that wraps.
REQ-022 load coincident with a slot boundary SHALL let the boundary use old shadow values; the new values apply from the next boundary.
REQ-023 The prescaler SHALL not be reset by load.

Reset
REQ-024 On rst high at a clock edge: prescaler=0, an=0, hex=0, blank=0, frame=0, shadow d=0, shadow digit_en=8'hFF, shadow cursor=0, blink counter=0, blink phase=on.
REQ-025 rst SHALL take priority over load and over a coincident slot boundary.

Configuration
REQ-026 Macro SEG_SCAN_CURSOR_BLINK_EN SHALL compile the cursor-blink feature in or out.
REQ-027 With the macro defined, a blink counter SHALL count frame pulses; every BLINK_DIV frames the blink phase toggles; during the off phase the shadow cursor digit is blink-suppressed.
REQ-028 Without the macro, no blink counter SHALL exist and no digit is ever blink-suppressed; cursor input is ignored.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-029 Reset, no load -> an steps 0,1,...,7,0 every 4 cycles; hex=0; frame pulses on each 7->0 step (every 32 cycles).
REQ-030 load with d=32'h76543210, digit_en=8'hFF -> hex equals an at each slot after the next boundary.
REQ-031 load with digit_en=8'b00100100 -> an alternates 2,5,2; frame on each 5->2 step; disabled digits never appear.
REQ-032 load with digit_en=8'h00 -> blank=1 from next boundary, an/hex frozen; subsequent load with 8'h01 -> blank=0, an=0, frame every 4 cycles.
REQ-033 Macro defined, digit_en=8'hFF, cursor=3 -> digit 3 shown in frames 0-1, skipped in frames 2-3 (an goes 2->4); macro undefined -> digit 3 never skipped.
REQ-034 rst asserted mid-scan while load=1 -> next cycle an=0, hex=0, blank=0, shadow digit_en=8'hFF; load data discarded.
